// File: rtl/frdn_pkg.sv
// Shared types for the layer weight-load path.
package frdn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } loader_state;

endpackage

// File: rtl/layer_weight_loader.sv
// Streams NEURONS x INPUTS weight words into a layer's weight-write port,
// neuron-major, with one-cycle write latency and a done pulse after the last write.
module layer_weight_loader
  import frdn_pkg::*;
#(
  parameter int INPUTS  = 400,
  parameter int NEURONS = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       in_valid,
  input  logic [63:0]                in_data,
  output logic                       in_ready,
  output logic                       write_weight,
  output logic [$clog2(NEURONS)-1:0] neuron_sel,
  output logic [$clog2(INPUTS)-1:0]  weight_sel,
  output logic [63:0]                weight_bus,
  output logic                       busy,
  output logic                       done
);

  localparam int WSW = $clog2(INPUTS);
  localparam int NSW = $clog2(NEURONS);
  localparam int WCW = WSW + 1;
  localparam int NCW = NSW + 1;
  localparam logic [WCW-1:0] W_LAST = WCW'(INPUTS - 1);
  localparam logic [NCW-1:0] N_LAST = NCW'(NEURONS - 1);

  loader_state state, state_nxt;
  logic [WCW-1:0] wcnt;
  logic [NCW-1:0] ncnt;
  logic           accept;
  logic           last_word;

  assign accept    = in_valid && in_ready;
  assign last_word = accept && (wcnt == W_LAST) && (ncnt == N_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state != IDLE && abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = LOAD;
        LOAD:    if (last_word) state_nxt = FLUSH;
        FLUSH:   state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // in_ready drops with abort so the word offered alongside it is not taken.
  always_comb begin
    in_ready = (state == LOAD) && !abort;
    busy     = (state != IDLE);
    done     = (state == DONE);
  end

  // Counters park on the final index rather than wrapping past it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= '0;
      ncnt <= '0;
    end else if (state == IDLE && start) begin
      wcnt <= '0;
      ncnt <= '0;
    end else if (accept) begin
      if (wcnt == W_LAST) begin
        if (ncnt != N_LAST) begin
          wcnt <= '0;
          ncnt <= ncnt + 1'b1;
        end
      end else begin
        wcnt <= wcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_weight <= 1'b0;
      neuron_sel   <= '0;
      weight_sel   <= '0;
      weight_bus   <= '0;
    end else begin
      write_weight <= accept;
      if (accept) begin
        neuron_sel <= ncnt[NSW-1:0];
        weight_sel <= wcnt[WSW-1:0];
        weight_bus <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_layer_weight_loader.sv
// Scoreboard bench for layer_weight_loader with a 4-input, 3-neuron layer.
module tb_layer_weight_loader;

  localparam int IN = 4;
  localparam int NR = 3;
  localparam int NW = IN * NR;

  logic        clk = 1'b0;
  logic        rst, start, abort, in_valid;
  logic [63:0] in_data;
  logic        in_ready, write_weight, busy, done;
  logic [1:0]  neuron_sel;
  logic [1:0]  weight_sel;
  logic [63:0] weight_bus;

  typedef struct {
    int          n;
    int          w;
    logic [63:0] d;
  } wr_t;

  wr_t sbq[$];
  int  n_chk = 0;
  int  n_fail = 0;
  int  done_cnt = 0;

  layer_weight_loader #(.INPUTS(IN), .NEURONS(NR)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .write_weight(write_weight), .neuron_sel(neuron_sel),
    .weight_sel(weight_sel), .weight_bus(weight_bus),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    wr_t e;
    if (!rst) begin
      if (done) begin
        done_cnt++;
        chk("wr_in_done", {63'd0, write_weight}, 64'd0);
      end
      if (write_weight) begin
        if (sbq.size() == 0) begin
          chk("unexpected_write", 64'd1, 64'd0);
        end else begin
          e = sbq.pop_front();
          chk("nsel", {62'd0, neuron_sel}, 64'(e.n));
          chk("wsel", {62'd0, weight_sel}, 64'(e.w));
          chk("wbus", weight_bus, e.d);
        end
      end
    end
  end

  // Entered and left 1 time unit after a rising edge, with the DUT in IDLE.
  task automatic run_load(input int gap, input int restart_at, input int abort_at);
    int i   = 0;
    int cyc = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ready_load", {63'd0, in_ready}, 64'd1);
    chk("busy_load", {63'd0, busy}, 64'd1);
    while (i < NW && cyc < 100) begin
      in_valid = (gap != 0) ? (cyc % 2 == 0) : 1'b1;
      start    = (i == restart_at) && in_valid;
      abort    = (i == abort_at) && in_valid;
      in_data  = 64'h100 + 64'(i);
      if (abort) begin
        #1 chk("ready_abort", {63'd0, in_ready}, 64'd0);
      end else if (in_valid) begin
        sbq.push_back('{i / IN, i % IN, 64'h100 + 64'(i)});
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (abort) begin
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("busy_abort", {63'd0, busy}, 64'd0);
        chk("ready_after_abort", {63'd0, in_ready}, 64'd0);
        return;
      end
      if (in_valid) i++;
      cyc++;
    end
    in_valid = 1'b0;
    if (cyc >= 100) chk("load_timeout", 64'(i), 64'(NW));
    chk("flush_busy", {63'd0, busy}, 64'd1);
    chk("flush_ready", {63'd0, in_ready}, 64'd0);
    chk("flush_done", {63'd0, done}, 64'd0);
    @(posedge clk); #1;
    chk("done_pulse", {63'd0, done}, 64'd1);
    @(posedge clk); #1;
    chk("idle_busy", {63'd0, busy}, 64'd0);
    chk("idle_done", {63'd0, done}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    #12;
    chk("rst_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_write", {63'd0, write_weight}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_nsel", {62'd0, neuron_sel}, 64'd0);
    chk("rst_wsel", {62'd0, weight_sel}, 64'd0);
    chk("rst_wbus", weight_bus, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_load(0, -1, -1);
    chk("done_cnt_full", 64'(done_cnt), 64'd1);
    chk("q_empty_full", 64'(sbq.size()), 64'd0);

    run_load(1, -1, -1);
    chk("done_cnt_gap", 64'(done_cnt), 64'd2);
    chk("q_empty_gap", 64'(sbq.size()), 64'd0);

    run_load(0, 5, -1);
    chk("done_cnt_restart", 64'(done_cnt), 64'd3);
    chk("q_empty_restart", 64'(sbq.size()), 64'd0);

    run_load(0, -1, 7);
    repeat (3) @(posedge clk);
    #1;
    chk("done_cnt_abort", 64'(done_cnt), 64'd3);
    chk("q_empty_abort", 64'(sbq.size()), 64'd0);
    run_load(0, -1, -1);
    chk("done_cnt_reload", 64'(done_cnt), 64'd4);

    // back-to-back: start in the cycle right after done
    run_load(0, -1, -1);
    chk("done_cnt_b2b", 64'(done_cnt), 64'd5);
    chk("q_empty_b2b", 64'(sbq.size()), 64'd0);

    // asynchronous reset in the middle of a run
    dc = done_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = 64'h100 + 64'(k);
      sbq.push_back('{k / IN, k % IN, 64'h100 + 64'(k)});
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #6;
    rst = 1'b1;
    #1;
    chk("mid_rst_write", {63'd0, write_weight}, 64'd0);
    chk("mid_rst_ready", {63'd0, in_ready}, 64'd0);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_done", {63'd0, done}, 64'd0);
    chk("mid_rst_nsel", {62'd0, neuron_sel}, 64'd0);
    chk("mid_rst_wsel", {62'd0, weight_sel}, 64'd0);
    chk("mid_rst_wbus", weight_bus, 64'd0);
    sbq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_busy", {63'd0, busy}, 64'd0);
    chk("post_rst_done_cnt", 64'(done_cnt), 64'(dc));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
